// File: rtl/alu_pkg.sv
// alu_pkg: shared types for the multi-cycle ALU.
//   OPW          opcode width (fixed at 4)
//   alu_op_t     opcode encoding
//   state_t      control FSM states
//   is_iterative true for opcodes that use the multi-cycle datapath
package alu_pkg;

   localparam int unsigned OPW = 4;

   typedef enum logic [OPW-1:0] {
      OP_ADD  = 4'b0000,
      OP_SUB  = 4'b0001,
      OP_MUL  = 4'b0010,
      OP_DIV  = 4'b0011,
      OP_SHL1 = 4'b0100,
      OP_SHR1 = 4'b0101,
      OP_ROL1 = 4'b0110,
      OP_ROR1 = 4'b0111,
      OP_AND  = 4'b1000,
      OP_OR   = 4'b1001,
      OP_XOR  = 4'b1010,
      OP_NOR  = 4'b1011,
      OP_NAND = 4'b1100,
      OP_XNOR = 4'b1101,
      OP_GT   = 4'b1110,
      OP_EQ   = 4'b1111
   } alu_op_t;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } state_t;

   function automatic logic is_iterative(input alu_op_t op);
      return (op == OP_MUL) || (op == OP_DIV);
   endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// alu_muldiv_iter: shared WIDTH-iteration shift-add multiplier / restoring
// divider.
//   clk, reset        clock, synchronous active-high reset
//   start             load operands and begin WIDTH iterations
//   is_div            1 = unsigned divide, 0 = multiply
//   a, b              operands (sampled on start)
//   done              current cycle performs the final iteration
//   prod_hi, prod_lo  product halves after this cycle's iteration
//   quot              quotient after this cycle's iteration
module alu_muldiv_iter #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             is_div,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             done,
   output logic [WIDTH-1:0] prod_hi,
   output logic [WIDTH-1:0] prod_lo,
   output logic [WIDTH-1:0] quot
);

   localparam int unsigned CW = $clog2(WIDTH + 1);

   logic [CW-1:0]    count;
   logic             div_q;
   // hi holds the partial product high half (MUL) or partial remainder (DIV);
   // lo holds the multiplier being shifted out (MUL) or dividend/quotient (DIV).
   logic [WIDTH-1:0] hi, lo, bq;
   logic [WIDTH-1:0] hi_n, lo_n;
   logic [WIDTH:0]   sum, shifted;

   always_comb begin
      sum     = {1'b0, hi} + (lo[0] ? {1'b0, bq} : '0);
      shifted = {hi, lo[WIDTH-1]};
      if (div_q) begin
         if (shifted >= {1'b0, bq}) begin
            // remainder < divisor, so the low WIDTH bits carry the full difference
            hi_n = shifted[WIDTH-1:0] - bq;
            lo_n = {lo[WIDTH-2:0], 1'b1};
         end else begin
            hi_n = shifted[WIDTH-1:0];
            lo_n = {lo[WIDTH-2:0], 1'b0};
         end
      end else begin
         hi_n = sum[WIDTH:1];
         lo_n = {sum[0], lo[WIDTH-1:1]};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count <= '0;
         div_q <= 1'b0;
         hi    <= '0;
         lo    <= '0;
         bq    <= '0;
      end else if (start) begin
         count <= CW'(WIDTH);
         div_q <= is_div;
         hi    <= '0;
         lo    <= a;
         bq    <= b;
      end else if (count != '0) begin
         count <= count - 1'b1;
         hi    <= hi_n;
         lo    <= lo_n;
      end
   end

   // Final values are exposed combinationally so the caller can register them
   // on the same edge as the last iteration (WIDTH+1 cycle latency overall).
   assign done    = (count == CW'(1));
   assign prod_hi = hi_n;
   assign prod_lo = lo_n;
   assign quot    = lo_n;

endmodule

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle parametrised ALU with valid/ready handshakes.
//   clk, reset          clock, synchronous active-high reset
//   in_valid, in_ready  operand-side handshake
//   a, b, op            operands and opcode (alu_pkg::alu_op_t encoding)
//   out_valid,out_ready result-side handshake
//   result              registered WIDTH-bit result
//   flag_z/c/v/dz       zero, carry/borrow/high-nonzero, overflow, div-by-zero
module alu_mc
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [OPW-1:0]   op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             flag_z,
   output logic             flag_c,
   output logic             flag_v,
   output logic             flag_dz
);

   state_t           state, state_n;
   alu_op_t          op_e, op_q, op_n;
   logic [WIDTH-1:0] res_q, res_n;
   logic             z_q, z_n, c_q, c_n, v_q, v_n, dz_q, dz_n;

   logic             accept, start, div_zero;
   logic [WIDTH-1:0] alu_res;
   logic             alu_c, alu_v;
   logic [WIDTH:0]   ext;

   logic             iter_done;
   logic [WIDTH-1:0] prod_hi, prod_lo, quot;

   assign op_e     = alu_op_t'(op);
   assign in_ready = (state == IDLE);
   assign accept   = in_valid && in_ready;
   assign div_zero = (op_e == OP_DIV) && (b == '0);
   assign start    = accept && is_iterative(op_e) && !div_zero;

   alu_muldiv_iter #(
      .WIDTH (WIDTH)
   ) u_iter (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .is_div  (op_e == OP_DIV),
      .a       (a),
      .b       (b),
      .done    (iter_done),
      .prod_hi (prod_hi),
      .prod_lo (prod_lo),
      .quot    (quot)
   );

   // Single-cycle operations
   always_comb begin
      alu_res = '0;
      alu_c   = 1'b0;
      alu_v   = 1'b0;
      ext     = '0;
      case (op_e)
         OP_ADD: begin
            ext     = {1'b0, a} + {1'b0, b};
            alu_res = ext[WIDTH-1:0];
            alu_c   = ext[WIDTH];
            alu_v   = (a[WIDTH-1] == b[WIDTH-1]) && (alu_res[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SUB: begin
            ext     = {1'b0, a} - {1'b0, b};
            alu_res = ext[WIDTH-1:0];
            alu_c   = ext[WIDTH];
            alu_v   = (a[WIDTH-1] != b[WIDTH-1]) && (alu_res[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SHL1: begin
            alu_res = {a[WIDTH-2:0], 1'b0};
            alu_c   = a[WIDTH-1];
         end
         OP_SHR1: begin
            alu_res = {1'b0, a[WIDTH-1:1]};
            alu_c   = a[0];
         end
         OP_ROL1: begin
            alu_res = {a[WIDTH-2:0], a[WIDTH-1]};
            alu_c   = a[WIDTH-1];
         end
         OP_ROR1: begin
            alu_res = {a[0], a[WIDTH-1:1]};
            alu_c   = a[0];
         end
         OP_AND:  alu_res = a & b;
         OP_OR:   alu_res = a | b;
         OP_XOR:  alu_res = a ^ b;
         OP_NOR:  alu_res = ~(a | b);
         OP_NAND: alu_res = ~(a & b);
         OP_XNOR: alu_res = ~(a ^ b);
         OP_GT:   alu_res = {{(WIDTH-1){1'b0}}, (a > b)};
         OP_EQ:   alu_res = {{(WIDTH-1){1'b0}}, (a == b)};
         default: ;
      endcase
   end

   // FSM next-state and result/flag capture
   always_comb begin
      state_n = state;
      op_n    = op_q;
      res_n   = res_q;
      z_n     = z_q;
      c_n     = c_q;
      v_n     = v_q;
      dz_n    = dz_q;
      case (state)
         IDLE: begin
            if (accept) begin
               op_n = op_e;
               if (div_zero) begin
                  res_n   = '1;
                  z_n     = 1'b0;
                  c_n     = 1'b0;
                  v_n     = 1'b0;
                  dz_n    = 1'b1;
                  state_n = DONE;
               end else if (is_iterative(op_e)) begin
                  state_n = BUSY;
               end else begin
                  res_n   = alu_res;
                  z_n     = (alu_res == '0);
                  c_n     = alu_c;
                  v_n     = alu_v;
                  dz_n    = 1'b0;
                  state_n = DONE;
               end
            end
         end
         BUSY: begin
            if (iter_done) begin
               if (op_q == OP_DIV) begin
                  res_n = quot;
                  z_n   = (quot == '0);
                  c_n   = 1'b0;
               end else begin
                  res_n = prod_lo;
                  z_n   = (prod_lo == '0);
                  c_n   = (prod_hi != '0);
               end
               v_n     = 1'b0;
               dz_n    = 1'b0;
               state_n = DONE;
            end
         end
         DONE: begin
            if (out_ready) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         op_q  <= OP_ADD;
         res_q <= '0;
         z_q   <= 1'b0;
         c_q   <= 1'b0;
         v_q   <= 1'b0;
         dz_q  <= 1'b0;
      end else begin
         state <= state_n;
         op_q  <= op_n;
         res_q <= res_n;
         z_q   <= z_n;
         c_q   <= c_n;
         v_q   <= v_n;
         dz_q  <= dz_n;
      end
   end

   assign out_valid = (state == DONE);
   assign result    = res_q;
   assign flag_z    = z_q;
   assign flag_c    = c_q;
   assign flag_v    = v_q;
   assign flag_dz   = dz_q;

endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
Parametrised multi-cycle ALU for the datapath, the successor to the 8-bit combinational ALU.
- Generalises operand width via WIDTH and adds flags.
- Replaces the combinational multiply/divide with an iterative shift-add multiplier and restoring divider.
- Wraps everything in a valid/ready handshake, so the block sits between an operand-issue stage and a writeback stage with backpressure on both sides.

Parameters:
- WIDTH, 8, operand and result width in bits (legal range 4..32).
- OPW, 4, opcode width (fixed at 4; exposed for the package only).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  operands and opcode present.
- in_ready  out  1  block can accept an operation.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- op  in  4  opcode (alu_pkg::alu_op_t).
- out_valid  out  1  result and flags valid.
- out_ready  in  1  consumer accepts the result.
- result  out  WIDTH  registered result.
- flag_z  out  1  result == 0.
- flag_c  out  1  carry/borrow/multiply high-part-nonzero.
- flag_v  out  1  signed overflow (add/sub only, else 0).
- flag_dz  out  1  divide by zero (DIV only, else 0).

Behaviour:
- One clock; reset is synchronous and active-high.
  - On reset: state=IDLE, in_ready=1, out_valid=0, result=0, all flags=0.
  - Reset mid-MUL/DIV aborts the operation; no result is ever presented for it.
- Opcode map:
  - 0000 ADD
  - 0001 SUB (a-b)
  - 0010 MUL (low WIDTH bits)
  - 0011 DIV (quotient, unsigned)
  - 0100 SHL1
  - 0101 SHR1 (logical)
  - 0110 ROL1
  - 0111 ROR1
  - 1000 AND
  - 1001 OR
  - 1010 XOR
  - 1011 NOR
  - 1100 NAND
  - 1101 XNOR
  - 1110 GT (unsigned, result 1/0)
  - 1111 EQ (result 1/0)
- States IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1.
  - Accept occurs when in_valid && in_ready; a, b and op are captured.
  - Single-cycle op: result and flags registered on the accept edge, go to DONE (out_valid=1 the next cycle; latency 1).
  - MUL/DIV: go to BUSY, counter loaded with WIDTH.
  - DIV with b==0: skip BUSY, go straight to DONE with result = all ones, flag_dz=1, latency 1.
- BUSY:
  - in_ready=0.
  - One iteration per cycle; counter decrements.
  - When the counter reaches 0, register the result and go to DONE.
  - MUL/DIV latency is WIDTH+1 cycles from accept to out_valid.
- DONE:
  - out_valid=1; in_ready=0.
  - result and flags are held stable while out_valid && !out_ready.
  - On out_ready, return to IDLE; out_valid drops the next cycle.
- Throughput: at most one op per 2 cycles; no accept in the same cycle as a DONE handshake.
- Arithmetic and flags:
  - ADD/SUB use a WIDTH+1-bit sum.
  - flag_c = carry out (ADD) or borrow (SUB, set when a<b).
  - flag_v = signed overflow of the WIDTH-bit result.
  - MUL uses a 2*WIDTH product; flag_c = (high half != 0).
  - Shifts/rotates: flag_c = the bit shifted or rotated out.
  - Logic/GT/EQ: flag_c=0.
  - flag_z is computed for all ops from the WIDTH-bit result.
- Inputs a, b and op are ignored whenever in_ready=0.

Decomposition:
- alu_pkg holds:
  - alu_op_t enum with the 4-bit opcodes above.
  - state_t enum (IDLE, BUSY, DONE).
  - localparam helper is_iterative(op).
- One sub-module, alu_muldiv_iter:
  - Ports: start, is_div, a, b; outputs done, prod_hi, prod_lo, quot.
  - Shared WIDTH-cycle shift/accumulate datapath for both MUL and DIV.
- alu_mc keeps the FSM, the single-cycle ops and the flag logic.

Test Plan:
1. WIDTH=8, ADD a=0xFF b=0x01 -> one cycle after accept: result=0x00, z=1, c=1, v=0; SUB a=0x80 b=0x01 -> result=0x7F, v=1, c=0.
2. MUL a=200 b=3 -> out_valid exactly 9 cycles after accept, result=0x58, c=1; MUL a=12 b=10 -> 0x78, c=0.
3. DIV a=100 b=7 -> out_valid at 9 cycles, result=14, dz=0; DIV a=5 b=0 -> 1 cycle, result=0xFF, dz=1.
4. Backpressure: ROL1 a=0x81 with out_ready=0 for 5 cycles -> result=0x03, c=1 held stable; in_ready=0 throughout; handshake completes when out_ready=1; in_ready=1 the next cycle.
5. Reset asserted 4 cycles into DIV -> next cycle in_ready=1, out_valid=0, result=0; a following EQ a=b=0x3C -> result=1, z=0.
6. Sweep all 16 opcodes with a=0x01 b=0x01, plus random WIDTH=16 operands, against a reference model -> every result and flag matches.
